// File: rtl/dsc_byp_c2h.sv
// -----------------------------------------------------------------------------
// dsc_byp_c2h
//   C2H descriptor-bypass loopback. Descriptors the QDMA emits on
//   c2h_byp_out_* are consumed and, when bypass is enabled, returned on the MM
//   (c2h_byp_in_mm_*) or ST cache (c2h_byp_in_st_csh_*) bypass-in port.
//   Each return path sits behind a registered 2-entry skid buffer, so there is
//   never a combinational vld->rdy path around the loop. Marker responses are
//   consumed and reported as 1-cycle pulses; a user marker request is attached
//   to the next MM descriptor that gets buffered. Per-path wrap-around
//   counters track bypass-in hand-offs.
//
// Ports
//   i_user_clk / i_user_reset        clock, synchronous active-high reset
//   i_c2h_dsc_bypass                 1: loop back, 0: consume and drop
//   i_c2h_mm_marker_req              pulse, mark the next MM descriptor
//   o_c2h_mm/st_marker_rsp           pulse, marker response accepted
//   i_c2h_byp_out_*                  descriptor in (vld/rdy)
//   o_c2h_byp_in_mm_*                MM descriptor out (vld/rdy)
//   o_c2h_byp_in_st_csh_*            ST cache descriptor out (vld/rdy)
//   o_c2h_mm/st_dsc_cnt              bypass-in hand-off counters
// -----------------------------------------------------------------------------
module dsc_byp_c2h #(
  parameter int CNT_W = 32
) (
  input  logic               i_user_clk,
  input  logic               i_user_reset,
  input  logic               i_c2h_dsc_bypass,
  input  logic               i_c2h_mm_marker_req,
  output logic               o_c2h_mm_marker_rsp,
  output logic               o_c2h_st_marker_rsp,
  input  logic [255:0]       i_c2h_byp_out_dsc,
  input  logic               i_c2h_byp_out_st_mm,
  input  logic               i_c2h_byp_out_mrkr_rsp,
  input  logic               i_c2h_byp_out_error,
  input  logic [10:0]        i_c2h_byp_out_qid,
  input  logic [7:0]         i_c2h_byp_out_func,
  input  logic [15:0]        i_c2h_byp_out_cidx,
  input  logic [2:0]         i_c2h_byp_out_port_id,
  input  logic [6:0]         i_c2h_byp_out_pfch_tag,
  input  logic               i_c2h_byp_out_vld,
  output logic               o_c2h_byp_out_rdy,
  output logic [63:0]        o_c2h_byp_in_mm_radr,
  output logic [63:0]        o_c2h_byp_in_mm_wadr,
  output logic [27:0]        o_c2h_byp_in_mm_len,
  output logic               o_c2h_byp_in_mm_mrkr_req,
  output logic               o_c2h_byp_in_mm_sdi,
  output logic               o_c2h_byp_in_mm_no_dma,
  output logic               o_c2h_byp_in_mm_error,
  output logic [10:0]        o_c2h_byp_in_mm_qid,
  output logic [7:0]         o_c2h_byp_in_mm_func,
  output logic [15:0]        o_c2h_byp_in_mm_cidx,
  output logic [2:0]         o_c2h_byp_in_mm_port_id,
  output logic               o_c2h_byp_in_mm_vld,
  input  logic               i_c2h_byp_in_mm_rdy,
  output logic [63:0]        o_c2h_byp_in_st_csh_addr,
  output logic [10:0]        o_c2h_byp_in_st_csh_qid,
  output logic [7:0]         o_c2h_byp_in_st_csh_func,
  output logic [2:0]         o_c2h_byp_in_st_csh_port_id,
  output logic [6:0]         o_c2h_byp_in_st_csh_pfch_tag,
  output logic               o_c2h_byp_in_st_csh_error,
  output logic               o_c2h_byp_in_st_csh_vld,
  input  logic               i_c2h_byp_in_st_csh_rdy,
  output logic [CNT_W-1:0]   o_c2h_mm_dsc_cnt,
  output logic [CNT_W-1:0]   o_c2h_st_dsc_cnt
);

  typedef struct packed {
    logic [63:0] radr;
    logic [63:0] wadr;
    logic [27:0] len;
    logic        mrkr_req;
    logic        sdi;
    logic        error;
    logic [10:0] qid;
    logic [7:0]  func;
    logic [15:0] cidx;
    logic [2:0]  port_id;
  } mm_beat_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [10:0] qid;
    logic [7:0]  func;
    logic [2:0]  port_id;
    logic [6:0]  pfch_tag;
    logic        error;
  } st_beat_t;

  // Buffer state: main register drives the port, skid register catches one
  // extra beat. A buffer is full exactly when its skid entry is occupied.
  logic       r_mm_vld, r_mm_skid_vld;
  mm_beat_t   r_mm_main, r_mm_skid;
  logic       r_st_vld, r_st_skid_vld;
  st_beat_t   r_st_main, r_st_skid;
  logic       r_mrkr_pend;
  logic [CNT_W-1:0] r_mm_cnt, r_st_cnt;

  logic       w_acc, w_fwd, w_mm_push, w_st_push, w_mm_pop, w_st_pop;
  mm_beat_t   w_mm_beat;
  st_beat_t   w_st_beat;
  logic       w_unused_dsc;

  // Descriptor bits that neither return path carries.
  assign w_unused_dsc = ^{i_c2h_byp_out_dsc[255:192], i_c2h_byp_out_dsc[127:95],
                          i_c2h_byp_out_dsc[93:92]};

  // Upstream ready: markers and dropped descriptors never need buffer space.
  always_comb begin
    o_c2h_byp_out_rdy = 1'b0;
    if (i_user_reset) begin
      o_c2h_byp_out_rdy = 1'b0;
    end else if (i_c2h_byp_out_mrkr_rsp || !i_c2h_dsc_bypass) begin
      o_c2h_byp_out_rdy = 1'b1;
    end else if (i_c2h_byp_out_st_mm) begin
      o_c2h_byp_out_rdy = ~r_mm_skid_vld;
    end else begin
      o_c2h_byp_out_rdy = ~r_st_skid_vld;
    end
  end

  assign w_acc     = i_c2h_byp_out_vld & o_c2h_byp_out_rdy;
  assign w_fwd     = w_acc & ~i_c2h_byp_out_mrkr_rsp & i_c2h_dsc_bypass;
  assign w_mm_push = w_fwd & i_c2h_byp_out_st_mm;
  assign w_st_push = w_fwd & ~i_c2h_byp_out_st_mm;
  assign w_mm_pop  = r_mm_vld & i_c2h_byp_in_mm_rdy;
  assign w_st_pop  = r_st_vld & i_c2h_byp_in_st_csh_rdy;

  assign o_c2h_mm_marker_rsp = w_acc & i_c2h_byp_out_mrkr_rsp & i_c2h_byp_out_st_mm;
  assign o_c2h_st_marker_rsp = w_acc & i_c2h_byp_out_mrkr_rsp & ~i_c2h_byp_out_st_mm;

  // Field mapping from the raw descriptor into the two beat formats.
  always_comb begin
    w_mm_beat          = '0;
    w_mm_beat.radr     = i_c2h_byp_out_dsc[63:0];
    w_mm_beat.len      = i_c2h_byp_out_dsc[91:64];
    w_mm_beat.sdi      = i_c2h_byp_out_dsc[94];
    w_mm_beat.wadr     = i_c2h_byp_out_dsc[191:128];
    // A request arriving in the same cycle as the write attaches to it.
    w_mm_beat.mrkr_req = r_mrkr_pend | i_c2h_mm_marker_req;
    w_mm_beat.error    = i_c2h_byp_out_error;
    w_mm_beat.qid      = i_c2h_byp_out_qid;
    w_mm_beat.func     = i_c2h_byp_out_func;
    w_mm_beat.cidx     = i_c2h_byp_out_cidx;
    w_mm_beat.port_id  = i_c2h_byp_out_port_id;
    w_st_beat          = '0;
    w_st_beat.addr     = i_c2h_byp_out_dsc[63:0];
    w_st_beat.qid      = i_c2h_byp_out_qid;
    w_st_beat.func     = i_c2h_byp_out_func;
    w_st_beat.port_id  = i_c2h_byp_out_port_id;
    w_st_beat.pfch_tag = i_c2h_byp_out_pfch_tag;
    w_st_beat.error    = i_c2h_byp_out_error;
  end

  // MM skid buffer. Push while full cannot occur because rdy is low then.
  always_ff @(posedge i_user_clk) begin
    if (i_user_reset) begin
      r_mm_vld      <= 1'b0;
      r_mm_skid_vld <= 1'b0;
      r_mm_main     <= '0;
      r_mm_skid     <= '0;
    end else if (w_mm_pop) begin
      if (r_mm_skid_vld) begin
        r_mm_main     <= r_mm_skid;
        r_mm_skid_vld <= 1'b0;
      end else if (w_mm_push) begin
        r_mm_main <= w_mm_beat;
      end else begin
        r_mm_vld <= 1'b0;
      end
    end else if (w_mm_push) begin
      if (r_mm_vld) begin
        r_mm_skid     <= w_mm_beat;
        r_mm_skid_vld <= 1'b1;
      end else begin
        r_mm_main <= w_mm_beat;
        r_mm_vld  <= 1'b1;
      end
    end
  end

  // ST skid buffer, same structure as the MM one.
  always_ff @(posedge i_user_clk) begin
    if (i_user_reset) begin
      r_st_vld      <= 1'b0;
      r_st_skid_vld <= 1'b0;
      r_st_main     <= '0;
      r_st_skid     <= '0;
    end else if (w_st_pop) begin
      if (r_st_skid_vld) begin
        r_st_main     <= r_st_skid;
        r_st_skid_vld <= 1'b0;
      end else if (w_st_push) begin
        r_st_main <= w_st_beat;
      end else begin
        r_st_vld <= 1'b0;
      end
    end else if (w_st_push) begin
      if (r_st_vld) begin
        r_st_skid     <= w_st_beat;
        r_st_skid_vld <= 1'b1;
      end else begin
        r_st_main <= w_st_beat;
        r_st_vld  <= 1'b1;
      end
    end
  end

  // Pending marker: set by a request, cleared when an MM beat is buffered.
  // Dropped descriptors leave it set; repeated requests merge.
  always_ff @(posedge i_user_clk) begin
    if (i_user_reset) begin
      r_mrkr_pend <= 1'b0;
    end else if (w_mm_push) begin
      r_mrkr_pend <= 1'b0;
    end else if (i_c2h_mm_marker_req) begin
      r_mrkr_pend <= 1'b1;
    end
  end

  // Hand-off counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge i_user_clk) begin
    if (i_user_reset) begin
      r_mm_cnt <= '0;
      r_st_cnt <= '0;
    end else begin
      if (w_mm_pop) r_mm_cnt <= r_mm_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_st_pop) r_st_cnt <= r_st_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_c2h_byp_in_mm_radr         = r_mm_main.radr;
  assign o_c2h_byp_in_mm_wadr         = r_mm_main.wadr;
  assign o_c2h_byp_in_mm_len          = r_mm_main.len;
  assign o_c2h_byp_in_mm_mrkr_req     = r_mm_main.mrkr_req;
  assign o_c2h_byp_in_mm_sdi          = r_mm_main.sdi;
  assign o_c2h_byp_in_mm_no_dma       = 1'b0;
  assign o_c2h_byp_in_mm_error        = r_mm_main.error;
  assign o_c2h_byp_in_mm_qid          = r_mm_main.qid;
  assign o_c2h_byp_in_mm_func         = r_mm_main.func;
  assign o_c2h_byp_in_mm_cidx         = r_mm_main.cidx;
  assign o_c2h_byp_in_mm_port_id      = r_mm_main.port_id;
  assign o_c2h_byp_in_mm_vld          = r_mm_vld;
  assign o_c2h_byp_in_st_csh_addr     = r_st_main.addr;
  assign o_c2h_byp_in_st_csh_qid      = r_st_main.qid;
  assign o_c2h_byp_in_st_csh_func     = r_st_main.func;
  assign o_c2h_byp_in_st_csh_port_id  = r_st_main.port_id;
  assign o_c2h_byp_in_st_csh_pfch_tag = r_st_main.pfch_tag;
  assign o_c2h_byp_in_st_csh_error    = r_st_main.error;
  assign o_c2h_byp_in_st_csh_vld      = r_st_vld;
  assign o_c2h_mm_dsc_cnt             = r_mm_cnt;
  assign o_c2h_st_dsc_cnt             = r_st_cnt;

endmodule

// File: tb/tb_dsc_byp_c2h.sv
module tb_dsc_byp_c2h;
  localparam int CNT_W = 4;

  logic clk, rst, byp, mreq, mm_mrsp, st_mrsp;
  logic [255:0] dsc;
  logic st_mm, mrkr, err, ovld, ordy;
  logic [10:0] qid;
  logic [7:0] func;
  logic [15:0] cidx;
  logic [2:0] port;
  logic [6:0] pfch;
  logic [63:0] mm_radr, mm_wadr, st_addr;
  logic [27:0] mm_len;
  logic mm_mrkr, mm_sdi, mm_nodma, mm_err, mm_vld, mm_rdy;
  logic [10:0] mm_qid, st_qid;
  logic [7:0] mm_func, st_func;
  logic [15:0] mm_cidx;
  logic [2:0] mm_port, st_port;
  logic [6:0] st_pfch;
  logic st_err, st_vld, st_rdy;
  logic [CNT_W-1:0] mm_cnt, st_cnt;

  dsc_byp_c2h #(.CNT_W(CNT_W)) dut (
    .i_user_clk(clk), .i_user_reset(rst), .i_c2h_dsc_bypass(byp),
    .i_c2h_mm_marker_req(mreq), .o_c2h_mm_marker_rsp(mm_mrsp), .o_c2h_st_marker_rsp(st_mrsp),
    .i_c2h_byp_out_dsc(dsc), .i_c2h_byp_out_st_mm(st_mm), .i_c2h_byp_out_mrkr_rsp(mrkr),
    .i_c2h_byp_out_error(err), .i_c2h_byp_out_qid(qid), .i_c2h_byp_out_func(func),
    .i_c2h_byp_out_cidx(cidx), .i_c2h_byp_out_port_id(port), .i_c2h_byp_out_pfch_tag(pfch),
    .i_c2h_byp_out_vld(ovld), .o_c2h_byp_out_rdy(ordy),
    .o_c2h_byp_in_mm_radr(mm_radr), .o_c2h_byp_in_mm_wadr(mm_wadr), .o_c2h_byp_in_mm_len(mm_len),
    .o_c2h_byp_in_mm_mrkr_req(mm_mrkr), .o_c2h_byp_in_mm_sdi(mm_sdi), .o_c2h_byp_in_mm_no_dma(mm_nodma),
    .o_c2h_byp_in_mm_error(mm_err), .o_c2h_byp_in_mm_qid(mm_qid), .o_c2h_byp_in_mm_func(mm_func),
    .o_c2h_byp_in_mm_cidx(mm_cidx), .o_c2h_byp_in_mm_port_id(mm_port), .o_c2h_byp_in_mm_vld(mm_vld),
    .i_c2h_byp_in_mm_rdy(mm_rdy),
    .o_c2h_byp_in_st_csh_addr(st_addr), .o_c2h_byp_in_st_csh_qid(st_qid),
    .o_c2h_byp_in_st_csh_func(st_func), .o_c2h_byp_in_st_csh_port_id(st_port),
    .o_c2h_byp_in_st_csh_pfch_tag(st_pfch), .o_c2h_byp_in_st_csh_error(st_err),
    .o_c2h_byp_in_st_csh_vld(st_vld), .i_c2h_byp_in_st_csh_rdy(st_rdy),
    .o_c2h_mm_dsc_cnt(mm_cnt), .o_c2h_st_dsc_cnt(st_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected beats per path, pending-marker flag, hand-off tallies.
  typedef struct {
    logic [63:0] radr, wadr;
    logic [27:0] len;
    logic mrkr, sdi, err;
    logic [10:0] qid;
    logic [7:0] func;
    logic [15:0] cidx;
    logic [2:0] port;
  } mm_exp_t;
  typedef struct {
    logic [63:0] addr;
    logic [10:0] qid;
    logic [7:0] func;
    logic [2:0] port;
    logic [6:0] pfch;
    logic err;
  } st_exp_t;

  mm_exp_t qmm[$];
  st_exp_t qst[$];
  bit pend = 1'b0;
  int mm_hs = 0, st_hs = 0;
  int n_tests = 0, n_fail = 0;

  // Stimulus knobs (percent, reset in per-mille)
  int p_vld, p_mm, p_ds, p_byp, p_mrk, p_req, p_rst;
  bit force_rst;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  task automatic step();
    logic exp_rdy, acc, req_now;
    mm_exp_t m;
    st_exp_t s;
    @(negedge clk);
    rst = force_rst | ($urandom_range(0, 999) < p_rst);
    ovld = pct(p_vld);
    for (int i = 0; i < 8; i++) dsc[i*32 +: 32] = $urandom();
    st_mm = pct(p_mm);
    mrkr = pct(p_mrk);
    err = 1'($urandom());
    qid = 11'($urandom());
    func = 8'($urandom());
    cidx = 16'($urandom());
    port = 3'($urandom());
    pfch = 7'($urandom());
    byp = pct(p_byp);
    mreq = pct(p_req);
    mm_rdy = pct(p_ds);
    st_rdy = pct(p_ds);
    #1;
    if (rst) exp_rdy = 1'b0;
    else if (mrkr || !byp) exp_rdy = 1'b1;
    else if (st_mm) exp_rdy = (qmm.size() < 2);
    else exp_rdy = (qst.size() < 2);
    chk("byp_out_rdy", 64'(ordy), 64'(exp_rdy));
    acc = ovld & exp_rdy;
    chk("mm_marker_rsp", 64'(mm_mrsp), 64'(acc & mrkr & st_mm));
    chk("st_marker_rsp", 64'(st_mrsp), 64'(acc & mrkr & ~st_mm));
    req_now = mreq;
    @(posedge clk);
    if (rst) begin
      qmm.delete();
      qst.delete();
      pend = 1'b0;
      mm_hs = 0;
      st_hs = 0;
    end else if (acc && !mrkr && byp && st_mm) begin
      m.radr = dsc[63:0];
      m.len = dsc[91:64];
      m.sdi = dsc[94];
      m.wadr = dsc[191:128];
      m.mrkr = pend | req_now;
      m.err = err; m.qid = qid; m.func = func; m.cidx = cidx; m.port = port;
      qmm.push_back(m);
      pend = 1'b0;
    end else begin
      if (acc && !mrkr && byp) begin
        s.addr = dsc[63:0];
        s.qid = qid; s.func = func; s.port = port; s.pfch = pfch; s.err = err;
        qst.push_back(s);
      end
      pend = pend | req_now;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares what the DUT presents against the head of each queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("mm_dsc_cnt", 64'(mm_cnt), 64'(mm_hs % (1 << CNT_W)));
      chk("st_dsc_cnt", 64'(st_cnt), 64'(st_hs % (1 << CNT_W)));
      chk("mm_vld", 64'(mm_vld), 64'(qmm.size() > 0));
      chk("st_vld", 64'(st_vld), 64'(qst.size() > 0));
      if (mm_vld && qmm.size() > 0) begin
        chk("mm_radr", mm_radr, qmm[0].radr);
        chk("mm_wadr", mm_wadr, qmm[0].wadr);
        chk("mm_len", 64'(mm_len), 64'(qmm[0].len));
        chk("mm_mrkr_req", 64'(mm_mrkr), 64'(qmm[0].mrkr));
        chk("mm_sdi", 64'(mm_sdi), 64'(qmm[0].sdi));
        chk("mm_no_dma", 64'(mm_nodma), 64'(0));
        chk("mm_error", 64'(mm_err), 64'(qmm[0].err));
        chk("mm_qid", 64'(mm_qid), 64'(qmm[0].qid));
        chk("mm_func", 64'(mm_func), 64'(qmm[0].func));
        chk("mm_cidx", 64'(mm_cidx), 64'(qmm[0].cidx));
        chk("mm_port", 64'(mm_port), 64'(qmm[0].port));
        if (mm_rdy) begin
          void'(qmm.pop_front());
          mm_hs++;
        end
      end
      if (st_vld && qst.size() > 0) begin
        chk("st_addr", st_addr, qst[0].addr);
        chk("st_qid", 64'(st_qid), 64'(qst[0].qid));
        chk("st_func", 64'(st_func), 64'(qst[0].func));
        chk("st_port", 64'(st_port), 64'(qst[0].port));
        chk("st_pfch", 64'(st_pfch), 64'(qst[0].pfch));
        chk("st_error", 64'(st_err), 64'(qst[0].err));
        if (st_rdy) begin
          void'(qst.pop_front());
          st_hs++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; byp = 1'b1; mreq = 1'b0; dsc = '0; st_mm = 1'b0; mrkr = 1'b0;
    err = 1'b0; qid = '0; func = '0; cidx = '0; port = '0; pfch = '0;
    ovld = 1'b0; mm_rdy = 1'b0; st_rdy = 1'b0;
    p_vld = 0; p_mm = 0; p_ds = 0; p_byp = 100; p_mrk = 0; p_req = 0; p_rst = 0;
    force_rst = 1'b1;
    run(3);
    force_rst = 1'b0;
    // Back-to-back MM with downstream always ready
    p_vld = 100; p_mm = 100; p_ds = 100;
    run(8);
    p_vld = 0;
    run(2);
    // ST stall: third descriptor must be held off, then drain in order
    p_vld = 100; p_mm = 0; p_ds = 0;
    run(4);
    p_vld = 0; p_ds = 100;
    run(4);
    // Marker request followed by MM beats, then marker responses
    p_req = 100;
    run(1);
    p_req = 0; p_vld = 100; p_mm = 100;
    run(3);
    p_mrk = 100; p_mm = 50;
    run(4);
    p_mrk = 0; p_vld = 0;
    run(2);
    // Bypass off: everything consumed, nothing forwarded; pending marker survives
    p_req = 100;
    run(1);
    p_req = 0; p_byp = 0; p_vld = 100; p_mm = 50;
    run(6);
    p_byp = 100; p_mm = 100;
    run(2);
    p_vld = 0;
    run(2);
    // Reset during a stall with two MM beats buffered and a marker pending
    p_vld = 100; p_mm = 100; p_ds = 0;
    run(2);
    p_vld = 0; p_req = 100;
    run(1);
    p_req = 0; force_rst = 1'b1;
    run(1);
    force_rst = 1'b0; p_vld = 100; p_ds = 100;
    run(4);
    // Long randomized mix, including counter wrap and sporadic resets
    p_vld = 70; p_mm = 50; p_ds = 60; p_byp = 85; p_mrk = 8; p_req = 10; p_rst = 3;
    run(4000);
    // Data outputs return to zero after reset
    p_rst = 0; force_rst = 1'b1;
    run(1);
    @(negedge clk);
    #3;
    chk("rst_mm_radr", mm_radr, 64'd0);
    chk("rst_mm_wadr", mm_wadr, 64'd0);
    chk("rst_mm_len", 64'(mm_len), 64'd0);
    chk("rst_mm_qid", 64'(mm_qid), 64'd0);
    chk("rst_st_addr", st_addr, 64'd0);
    chk("rst_st_pfch", 64'(st_pfch), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
